// File: rtl/mips_pkg.sv
// Constants and types shared by the register file, the control unit and the destination mux.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef logic [ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port of the register file, with optional write-to-read bypass.
module regfile_read_port
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W,
    parameter bit BYPASS = 1'b0
) (
    input  logic [ADDR_W-1:0] read_reg,
    input  logic [DATA_W-1:0] regs [2**ADDR_W],
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_reg,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] read_data
);

    always_comb begin
        read_data = regs[read_reg];
        // $0 wins over the bypass so a discarded write to index 0 never leaks out
        if (read_reg == ADDR_W'(REG_ZERO)) begin
            read_data = '0;
        end else if (BYPASS && wr_en && (wr_reg == read_reg)) begin
            read_data = wr_data;
        end
    end

endmodule

// File: rtl/mips_register_file.sv
// 32 x 32-bit MIPS register file: two operand read ports, a debug read port, one write port.
module mips_register_file
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W,
    parameter bit BYPASS = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_en;

    assign wr_en = reg_write && (write_reg != ADDR_W'(REG_ZERO));

    // regs[0] is never written, so it stays at its reset value of zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[write_reg] <= write_data;
        end
    end

    always @(posedge clk) begin
        if (rst_n && reg_write) begin
            assert (!$isunknown(write_reg));
        end
    end

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_port_rs (
        .read_reg  (read_reg1),
        .regs      (regs),
        .wr_en     (wr_en),
        .wr_reg    (write_reg),
        .wr_data   (write_data),
        .read_data (read_data1)
    );

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_port_rt (
        .read_reg  (read_reg2),
        .regs      (regs),
        .wr_en     (wr_en),
        .wr_reg    (write_reg),
        .wr_data   (write_data),
        .read_data (read_data2)
    );

    assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_mips_register_file.sv
// Directed bench for mips_register_file: one instance without and one with the write bypass.
module tb_mips_register_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [4:0]  dbg_addr;
    logic [31:0] rd1_nb, rd2_nb, dbg_nb;
    logic [31:0] rd1_bp, rd2_bp, dbg_bp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_nb (
        .clk        (clk),
        .rst_n      (rst_n),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .read_data1 (rd1_nb),
        .read_data2 (rd2_nb),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_nb)
    );

    mips_register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut_bp (
        .clk        (clk),
        .rst_n      (rst_n),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .read_data1 (rd1_bp),
        .read_data2 (rd2_bp),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_bp)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] idx, input logic [31:0] val);
        reg_write  = 1'b1;
        write_reg  = idx;
        write_data = val;
        tick();
        reg_write  = 1'b0;
        #1;
    endtask

    initial begin
        logic [31:0] exp;
        rst_n      = 1'b0;
        reg_write  = 1'b0;
        write_reg  = 5'd0;
        write_data = 32'h0;
        read_reg1  = 5'd10;
        read_reg2  = 5'd31;
        dbg_addr   = 5'd10;
        #1;
        check("reset_rd1", rd1_nb, 32'h0);
        check("reset_rd2", rd2_nb, 32'h0);
        check("reset_dbg", dbg_nb, 32'h0);

        // Release reset mid-cycle, load reg 10, then pulse reset mid-cycle
        tick();
        #2 rst_n = 1'b1;
        tick();
        wr(5'd10, 32'hDEADBEEF);
        check("load_r10", rd1_nb, 32'hDEADBEEF);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_rd1", rd1_nb, 32'h0);
        check("async_rst_dbg", dbg_nb, 32'h0);

        // Write attempted across an edge while reset is held: reset wins
        reg_write  = 1'b1;
        write_reg  = 5'd10;
        write_data = 32'h55AA55AA;
        tick();
        check("rst_beats_write", rd1_nb, 32'h0);
        check("rst_beats_write_bp_dbg", dbg_bp, 32'h0);
        reg_write = 1'b0;
        #2 rst_n = 1'b1;
        #1;
        check("after_release_no_write", rd1_nb, 32'h0);

        // Destination-mux style writes
        wr(5'b01010, 32'h0000_1234);
        wr(5'b11111, 32'hFFFF_0000);
        read_reg1 = 5'd10;
        read_reg2 = 5'd31;
        #1;
        check("dest_r10", rd1_nb, 32'h0000_1234);
        check("dest_r31", rd2_nb, 32'hFFFF_0000);
        check("dest_r10_bp", rd1_bp, 32'h0000_1234);

        // $0 protection before and after the edge
        read_reg1  = 5'd0;
        read_reg2  = 5'd0;
        dbg_addr   = 5'd0;
        reg_write  = 1'b1;
        write_reg  = 5'd0;
        write_data = 32'hFFFFFFFF;
        #1;
        check("r0_pre_rd1_bp", rd1_bp, 32'h0);
        check("r0_pre_rd2_bp", rd2_bp, 32'h0);
        check("r0_pre_dbg", dbg_nb, 32'h0);
        tick();
        reg_write = 1'b0;
        #1;
        check("r0_post_rd1", rd1_nb, 32'h0);
        check("r0_post_rd2", rd2_nb, 32'h0);
        check("r0_post_dbg", dbg_nb, 32'h0);
        check("r0_post_rd1_bp", rd1_bp, 32'h0);

        // Write-enable gating
        reg_write  = 1'b0;
        write_reg  = 5'd5;
        write_data = 32'hA5A5A5A5;
        read_reg1  = 5'd5;
        tick();
        check("we_gate_r5", rd1_nb, 32'h0);
        check("we_gate_r5_bp", rd1_bp, 32'h0);

        // Same-cycle read/write of reg 7
        wr(5'd7, 32'h11);
        read_reg1  = 5'd7;
        read_reg2  = 5'd7;
        dbg_addr   = 5'd7;
        reg_write  = 1'b1;
        write_reg  = 5'd7;
        write_data = 32'h22;
        #1;
        check("rw7_pre_nb", rd1_nb, 32'h11);
        check("rw7_pre_bp", rd1_bp, 32'h22);
        check("rw7_pre_bp_rd2", rd2_bp, 32'h22);
        check("rw7_pre_dbg_nb", dbg_nb, 32'h11);
        check("rw7_pre_dbg_bp", dbg_bp, 32'h11);
        tick();
        reg_write = 1'b0;
        #1;
        check("rw7_post_nb", rd1_nb, 32'h22);
        check("rw7_post_bp", rd1_bp, 32'h22);
        check("rw7_post_dbg", dbg_nb, 32'h22);

        // Dual read of reg 31
        read_reg1 = 5'd31;
        read_reg2 = 5'd31;
        #1;
        check("dual31_rd1", rd1_nb, 32'hFFFF_0000);
        check("dual31_rd2", rd2_nb, 32'hFFFF_0000);

        // Full sweep
        for (int i = 0; i < 32; i++) begin
            wr(5'(i), 32'(i) * 32'h01010101);
        end
        for (int i = 0; i < 32; i++) begin
            read_reg1 = 5'(i);
            read_reg2 = 5'(31 - i);
            dbg_addr  = 5'(i);
            #1;
            exp = (i == 0) ? 32'h0 : 32'(i) * 32'h01010101;
            check($sformatf("sweep_rd1_%0d", i), rd1_nb, exp);
            check($sformatf("sweep_dbg_%0d", i), dbg_nb, exp);
            check($sformatf("sweep_rd1_bp_%0d", i), rd1_bp, exp);
            exp = (i == 31) ? 32'h0 : 32'(31 - i) * 32'h01010101;
            check($sformatf("sweep_rd2_%0d", 31 - i), rd2_nb, exp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
